qdec_cnt_ctrl: RTL and testbench

- Quadrature-encoder front end. Drives the control side of the 16-bit up/down counter: load, load data, clear, count enable and direction.
- Synchronises and glitch-filters the encoder A/B/index inputs, decodes Gray-code steps into single-cycle count pulses, and turns the index mark and software load requests into clear/load strobes.
- Counts illegal A/B transitions.

---
 rtl/qdec_cnt_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_qdec_cnt_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdec_cnt_ctrl.sv
// Quadrature-encoder front end for a 16-bit up/down counter.
//
// Synchronises and glitch-filters encoder A/B/index, decodes Gray-code steps into
// single-cycle count pulses, turns index rising edges and software load requests
// into clear/load strobes, and counts illegal (both-bit) A/B transitions.
//
// Optional feature: define QDEC_X1_MODE_EN for x1 decode.
// In x1 decode, only 10->11 counts up and only 11->10 counts down.
// Without the macro, every legal A/B transition counts (x4 decode).
//
// Parameters:
//   FILT_LEN  consecutive differing cycles before a filtered input updates (1..15)
//   ERR_W     width of the saturating illegal-transition counter
//
// Ports:
//   i_sysclk, i_sysrst        clock, asynchronous active-high reset
//   i_a, i_b, i_idx           asynchronous encoder inputs
//   i_idx_clr_en              allow counter clear on index rising edge
//   i_ld_req, i_ld_val        single-cycle load request and its value
//   i_err_clr                 clear the error counter
//   o_ld, o_ld_data, o_clr    counter load/clear strobes and load data
//   o_cnt_en, o_dir           count pulse and direction (1=up)
//   o_err, o_err_cnt          illegal-transition pulse and saturating count
module qdec_cnt_ctrl #(
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             i_sysclk,
  input  logic             i_sysrst,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_idx,
  input  logic             i_idx_clr_en,
  input  logic             i_ld_req,
  input  logic [15:0]      i_ld_val,
  input  logic             i_err_clr,
  output logic             o_ld,
  output logic [15:0]      o_ld_data,
  output logic             o_clr,
  output logic             o_cnt_en,
  output logic             o_dir,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int unsigned FCW = 4;
  localparam int unsigned ICW = 5;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  // Channel order in the packed vectors: {a, b, idx}
  logic [2:0]     sync1_q, sync2_q, filt_q;
  logic [FCW-1:0] fcnt_q [3];

  logic [1:0] filt_ab;
  logic       filt_idx;
  assign filt_ab  = filt_q[2:1];
  assign filt_idx = filt_q[0];

  state_e         state_q, state_d;
  logic [ICW-1:0] init_cnt_q, init_cnt_d;
  logic [1:0]     prev_ab_q, prev_ab_d;
  logic           prev_idx_q, prev_idx_d;
  logic           step_d, up_d, err_d, idx_rise_d, fwd;
  logic           dec_step_q, dec_up_q, dec_err_q, dec_clr_q;

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      for (int i = 0; i < 3; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q <= {i_a, i_b, i_idx};
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FCW'(FILT_LEN - 1)) begin
          // This cycle is the FILT_LEN-th consecutive differing one
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_ab_d  = prev_ab_q;
    prev_idx_d = prev_idx_q;
    step_d     = 1'b0;
    up_d       = 1'b0;
    err_d      = 1'b0;
    idx_rise_d = 1'b0;
    fwd        = 1'b0;
    unique case (state_q)
      StInit: begin
        // Wait until the filters have settled on the post-reset input level
        if (init_cnt_q == ICW'(FILT_LEN + 2)) begin
          state_d    = StRun;
          prev_ab_d  = filt_ab;
          prev_idx_d = filt_idx;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      StRun: begin
        prev_ab_d  = filt_ab;
        prev_idx_d = filt_idx;
        idx_rise_d = filt_idx & ~prev_idx_q & i_idx_clr_en;
        case ({prev_ab_q, filt_ab})
          4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd = 1'b1;
          default:                            fwd = 1'b0;
        endcase
        if ((prev_ab_q ^ filt_ab) == 2'b11) begin
          err_d = 1'b1;
        end else if (prev_ab_q != filt_ab) begin
`ifdef QDEC_X1_MODE_EN
          step_d = ({prev_ab_q, filt_ab} == 4'b1011) || ({prev_ab_q, filt_ab} == 4'b1110);
          up_d   = (prev_ab_q == 2'b10);
`else
          step_d = 1'b1;
          up_d   = fwd;
`endif
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      prev_ab_q  <= '0;
      prev_idx_q <= 1'b0;
      dec_step_q <= 1'b0;
      dec_up_q   <= 1'b0;
      dec_err_q  <= 1'b0;
      dec_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_ab_q  <= prev_ab_d;
      prev_idx_q <= prev_idx_d;
      dec_step_q <= step_d;
      dec_up_q   <= up_d;
      dec_err_q  <= err_d;
      dec_clr_q  <= idx_rise_d;
    end
  end

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      o_ld      <= 1'b0;
      o_ld_data <= '0;
      o_clr     <= 1'b0;
      o_cnt_en  <= 1'b0;
      o_dir     <= 1'b1;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      o_ld     <= i_ld_req;
      // A load landing on the same cycle makes the clear meaningless
      o_clr    <= dec_clr_q & ~i_ld_req;
      o_cnt_en <= dec_step_q;
      o_err    <= dec_err_q;
      if (i_ld_req) o_ld_data <= i_ld_val;
      if (dec_step_q) o_dir <= dec_up_q;
      if (i_err_clr) begin
        o_err_cnt <= '0;
      end else if (dec_err_q && !(&o_err_cnt)) begin
        o_err_cnt <= o_err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qdec_cnt_ctrl.sv
// Directed self-checking bench for qdec_cnt_ctrl with FILT_LEN=3, ERR_W=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// A count pulse is expected 7 ticks after an input change: the first sampling
// edge is the next rising edge, plus FILT_LEN+3 cycles of pipeline.
module tb_qdec_cnt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        a, b, idx, idx_clr_en, ld_req, err_clr;
  logic [15:0] ld_val;
  logic        ld, clr, cnt_en, dir, err;
  logic [15:0] ld_data;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int cnt_en_seen = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  qdec_cnt_ctrl #(.FILT_LEN(3), .ERR_W(8)) dut (
    .i_sysclk(clk), .i_sysrst(rst), .i_a(a), .i_b(b), .i_idx(idx),
    .i_idx_clr_en(idx_clr_en), .i_ld_req(ld_req), .i_ld_val(ld_val), .i_err_clr(err_clr),
    .o_ld(ld), .o_ld_data(ld_data), .o_clr(clr), .o_cnt_en(cnt_en), .o_dir(dir),
    .o_err(err), .o_err_cnt(err_cnt)
  );

  always @(negedge clk) begin
    cnt_en_seen += int'(cnt_en);
    err_seen    += int'(err);
  end

  function automatic bit exp_pulse(input logic [1:0] p, input logic [1:0] c);
`ifdef QDEC_X1_MODE_EN
    return (p == 2'b10 && c == 2'b11) || (p == 2'b11 && c == 2'b10);
`else
    return (p != c) && ((p ^ c) != 2'b11);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] ab);
    rst = 1'b1;
    {a, b} = ab;
    tick();
    tick();
    rst = 1'b0;
    repeat (15) tick();
  endtask

  // Drive a new A/B level, hold 10 cycles, check pulse count, timing and direction
  task automatic step(input logic [1:0] from, input logic [1:0] ab, input bit exp_dir);
    int n = 0;
    int first = 0;
    bit ep;
    ep = exp_pulse(from, ab);
    {a, b} = ab;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (cnt_en === 1'b1) begin
        n++;
        if (first == 0) first = t;
      end
    end
    checks++;
    if (n !== int'(ep)) begin
      errors++;
      $display("FAIL step_pulses %b->%b: got %0d required %0d", from, ab, n, ep);
    end
    if (ep) begin
      checks++;
      if (first !== 7) begin
        errors++;
        $display("FAIL step_latency %b->%b: got tick %0d required 7", from, ab, first);
      end
      checks++;
      if (dir !== exp_dir) begin
        errors++;
        $display("FAIL step_dir %b->%b: got %b required %b", from, ab, dir, exp_dir);
      end
    end
  endtask

  task automatic test_reset();
    int c0, e0;
    rst = 1'b1; a = 1'b1; b = 1'b1; idx = 1'b0; idx_clr_en = 1'b0;
    ld_req = 1'b0; ld_val = 16'h0; err_clr = 1'b0;
    #2;
    checks++;
    if ({ld, ld_data, clr, cnt_en, dir, err, err_cnt} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset_values: got %b required %b",
               {ld, ld_data, clr, cnt_en, dir, err, err_cnt},
               {1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0});
    end
    tick();
    tick();
    c0 = cnt_en_seen; e0 = err_seen;
    rst = 1'b0;
    repeat (20) tick();
    checks++;
    if (cnt_en_seen - c0 !== 0) begin
      errors++;
      $display("FAIL reset_11_no_step: got %0d pulses required 0", cnt_en_seen - c0);
    end
    checks++;
    if (err_seen - e0 !== 0 || err_cnt !== 8'h0) begin
      errors++;
      $display("FAIL reset_11_no_err: got %0d pulses cnt %0d required 0 0", err_seen - e0, err_cnt);
    end
    checks++;
    if (dir !== 1'b1) begin
      errors++;
      $display("FAIL reset_11_dir: got %b required 1", dir);
    end
  endtask

  task automatic test_forward();
    step(2'b00, 2'b10, 1'b1);
    step(2'b10, 2'b11, 1'b1);
    step(2'b11, 2'b01, 1'b1);
    step(2'b01, 2'b00, 1'b1);
  endtask

  task automatic test_reverse();
    step(2'b00, 2'b01, 1'b0);
    step(2'b01, 2'b11, 1'b0);
    step(2'b11, 2'b10, 1'b0);
    step(2'b10, 2'b00, 1'b0);
  endtask

  task automatic test_glitch();
    int c0;
    c0 = cnt_en_seen;
    a = 1'b1;
    tick();
    tick();
    a = 1'b0;
    repeat (12) tick();
    checks++;
    if (cnt_en_seen - c0 !== 0) begin
      errors++;
      $display("FAIL glitch_2cyc: got %0d pulses required 0", cnt_en_seen - c0);
    end
    // A level held only 3 cycles still qualifies
    c0 = cnt_en_seen;
    a = 1'b1;
    repeat (3) tick();
    a = 1'b0;
    repeat (12) tick();
    checks++;
    if (cnt_en_seen - c0 !== 2 * int'(exp_pulse(2'b00, 2'b10))) begin
      errors++;
      $display("FAIL glitch_3cyc: got %0d pulses required %0d", cnt_en_seen - c0,
               2 * int'(exp_pulse(2'b00, 2'b10)));
    end
  endtask

  task automatic test_err_sat();
    int e0;
    e0 = err_seen;
    for (int i = 0; i < 300; i++) begin
      {a, b} = 2'b11;
      repeat (5) tick();
      {a, b} = 2'b01;
      repeat (5) tick();
      {a, b} = 2'b00;
      repeat (5) tick();
    end
    repeat (10) tick();
    checks++;
    if (err_seen - e0 !== 300) begin
      errors++;
      $display("FAIL err_pulses: got %0d required 300", err_seen - e0);
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL err_saturate: got %0d required 255", err_cnt);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL err_clear: got %0d required 0", err_cnt);
    end
  endtask

  task automatic test_index();
    int n, first;
    idx_clr_en = 1'b1;
    idx = 1'b1;
    repeat (6) tick();
    ld_req = 1'b1;
    ld_val = 16'h1234;
    tick();
    ld_req = 1'b0;
    ld_val = 16'h0;
    checks++;
    if ({ld, ld_data, clr} !== {1'b1, 16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL ld_vs_clr: got ld=%b data=%h clr=%b required 1 1234 0", ld, ld_data, clr);
    end
    tick();
    checks++;
    if (ld !== 1'b0 || clr !== 1'b0) begin
      errors++;
      $display("FAIL ld_single: got ld=%b clr=%b required 0 0", ld, clr);
    end
    idx = 1'b0;
    repeat (10) tick();
    idx = 1'b1;
    n = 0; first = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (clr === 1'b1) begin
        n++;
        if (first == 0) first = t;
      end
    end
    checks++;
    if (n !== 1 || first !== 7) begin
      errors++;
      $display("FAIL idx_clr: got %0d pulses at tick %0d required 1 at 7", n, first);
    end
    idx = 1'b0;
    repeat (10) tick();
    idx_clr_en = 1'b0;
    idx = 1'b1;
    n = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (clr === 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL idx_disabled: got %0d pulses required 0", n);
    end
    idx = 1'b0;
    repeat (10) tick();
    checks++;
    if (ld_data !== 16'h1234) begin
      errors++;
      $display("FAIL ld_data_hold: got %h required 1234", ld_data);
    end
  endtask

  task automatic test_mid_reset();
    int c0, e0;
    step(2'b00, 2'b10, 1'b1);
    step(2'b10, 2'b11, 1'b1);
    {a, b} = 2'b10;
    repeat (7) tick();
    checks++;
    if (cnt_en !== 1'b1 || dir !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_step: got cnt_en=%b dir=%b required 1 0", cnt_en, dir);
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({ld, ld_data, clr, cnt_en, dir, err, err_cnt} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL async_reset: got %b required %b",
               {ld, ld_data, clr, cnt_en, dir, err, err_cnt},
               {1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0});
    end
    tick();
    tick();
    c0 = cnt_en_seen; e0 = err_seen;
    rst = 1'b0;
    repeat (20) tick();
    checks++;
    if (cnt_en_seen - c0 !== 0 || err_seen - e0 !== 0) begin
      errors++;
      $display("FAIL post_reset_quiet: got %0d steps %0d errs required 0 0",
               cnt_en_seen - c0, err_seen - e0);
    end
  endtask

  initial begin
    test_reset();
    do_reset(2'b00);
    test_forward();
    test_reverse();
    test_glitch();
    test_err_sat();
    test_index();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
